maxpool1d_stream: RTL and testbench
===================================

# maxpool1d_stream

Streaming 1-D max-pool stage placed directly downstream of the ReLU activation block in the operator pipeline. It consumes the activation stream one 32-bit word per accepted beat and reduces each non-overlapping window of POOL_K words to its maximum. A `last_in` marker closes a partial window early at end of row. The block adds a one-entry output register with valid/ready backpressure, so the following stage may stall.

## Interface
- `DATA_W`, 32: word width; data is two's-complement signed.
- `POOL_K`, 2: window length, legal range 1..255; stride equals POOL_K.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset; deassertion is synchronous to `clk` upstream.
- `valid_in` input 1: `input_data` and `last_in` are valid this cycle.
- `ready_in` output 1: block can accept a beat this cycle.
- `input_data` input DATA_W: activation word, normally the ReLU output.
- `last_in` input 1: this beat is the final word of a row and closes the current window.
- `valid_out` output 1: output register holds a result.
- `ready_out` input 1: downstream accepts the result this cycle.
- `output_data` output DATA_W: window maximum.
- `last_out` output 1: result window was closed by `last_in`.
- `count_out` output 8: number of words pooled into this result, 1..POOL_K.

## Operation
- Accept occurs when `valid_in & ready_in`. Drain occurs when `valid_out & ready_out`.
- `ready_in = ~valid_out | ready_out`. This is a combinational path from `ready_out`; it is documented and allowed.
- Internal state:
  - `acc`: DATA_W bits, running maximum.
  - `cnt`: 8 bits, words accumulated in the open window, 0..POOL_K-1.
- On accept with `cnt==0`: the window max becomes `input_data`.
- On accept with `cnt>0`: the window max becomes the signed max of `acc` and `input_data`. On a tie, the value is unchanged.
- Window completes on accept when `cnt==POOL_K-1` or `last_in==1`. On completion:
  - Load `output_data` with the window max.
  - Load `count_out` with `cnt+1` and `last_out` with `last_in`.
  - Set `valid_out`=1 and clear `cnt` to 0.
- Non-completing accept: `acc` takes the window max and `cnt` increments. The output register is unchanged.
- Drain without a same-cycle completion: `valid_out` goes to 0. `output_data`, `count_out` and `last_out` hold their last values.
- Drain and completion in the same cycle: the new result loads and `valid_out` stays 1, giving no bubble.
- POOL_K=1: every accepted beat completes, and the block acts as a pass-through register with count 1.
- No accept in a cycle: `acc` and `cnt` hold. `valid_in` may drop mid-window without effect.
- Reset, asynchronous, at any time including mid-window: all state clears immediately and any partial window is discarded.

## Timing
- Reset values: `valid_out`=0, `output_data`=0, `last_out`=0, `count_out`=0, `acc`=0, `cnt`=0.
- `ready_in` reads 1 during and after reset.
- Latency: the result is visible on `valid_out` the cycle after the completing accept.
- Throughput: 1 word per cycle with `ready_out` held high.
- With `ready_out` held low and `valid_out`=1, `ready_in`=0. No beat is accepted and `acc`/`cnt` are frozen.
- Outputs remain stable while `valid_out & ~ready_out`.
- All outputs except `ready_in` are registered.

## Test plan
- Reset, then POOL_K=2, `ready_out`=1, inputs 3,7,9,2 -> `output_data`=7 with count 2, then 9 with count 2. Each result appears one cycle after its second input.
- POOL_K=3, inputs 5,1 with `last_in` on the 1 -> one result: 5, count 2, `last_out`=1. The next window starts fresh: 4,4,4 -> 4, count 3, `last_out`=0.
- Backpressure, POOL_K=2: hold `ready_out`=0 after the first result (value 7) is ready.
  - Required: `ready_in`=0, `output_data` stays 7, further inputs are not consumed.
  - Release `ready_out` -> 7 drains and the pending inputs are accepted in order.
- Signed compare, POOL_K=2: -5 (0xFFFFFFFB) then -9 -> -5. Then 0x80000000 and 0x7FFFFFFF -> 0x7FFFFFFF.
- Simultaneous drain and completion, continuous stream at `ready_out`=1, POOL_K=1, inputs 1..8 -> 8 back-to-back results with `valid_out` never dropping.
- Assert `rst_n`=0 after 1 input of a POOL_K=4 window. Then send 2,6,1,3 -> single result 6, count 4. The pre-reset word does not contribute.

Source files
------------

// File: rtl/maxpool1d_stream.sv
// Streaming 1-D max-pool stage.
//
// Consumes one signed DATA_W-bit word per accepted beat and reduces each
// non-overlapping window of POOL_K words to its maximum. A last_in beat closes
// the open window early (end of row). A one-entry output register with
// valid/ready handshaking lets the downstream stage stall.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   valid_in/ready_in input handshake; ready_in = ~valid_out | ready_out
//   input_data        signed activation word
//   last_in           final word of a row, closes the current window
//   valid_out/ready_out output handshake
//   output_data       window maximum
//   last_out          result window was closed by last_in
//   count_out         words pooled into this result, 1..POOL_K
//
// POOL_K must lie in 1..255 so that cnt fits in 8 bits.
module maxpool1d_stream #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned POOL_K = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] input_data,
  input  logic              last_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] output_data,
  output logic              last_out,
  output logic [7:0]        count_out
);

  localparam logic [7:0] LastIdx = 8'(POOL_K - 1);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              valid_out_q, valid_out_d;
  logic [DATA_W-1:0] output_data_q, output_data_d;
  logic              last_out_q, last_out_d;
  logic [7:0]        count_out_q, count_out_d;

  logic              accept;
  logic              drain;
  logic              complete;
  logic [DATA_W-1:0] win_max;

  // Combinational path from ready_out: a full register can take a new result
  // in the same cycle it drains.
  assign ready_in = ~valid_out_q | ready_out;
  assign accept   = valid_in & ready_in;
  assign drain    = valid_out_q & ready_out;
  assign complete = accept & ((cnt_q == LastIdx) | last_in);

  always_comb begin
    win_max = acc_q;
    if (cnt_q == 8'd0) begin
      // First word of a window overwrites whatever acc held.
      win_max = input_data;
    end else if ($signed(input_data) > $signed(acc_q)) begin
      // Strict compare: a tie keeps the existing maximum.
      win_max = input_data;
    end
  end

  always_comb begin
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    valid_out_d   = valid_out_q;
    output_data_d = output_data_q;
    last_out_d    = last_out_q;
    count_out_d   = count_out_q;

    if (drain) begin
      valid_out_d = 1'b0;
    end

    if (complete) begin
      // Loading a new result takes priority over the drain clear: no bubble.
      output_data_d = win_max;
      count_out_d   = cnt_q + 8'd1;
      last_out_d    = last_in;
      valid_out_d   = 1'b1;
      cnt_d         = 8'd0;
    end else if (accept) begin
      acc_d = win_max;
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      valid_out_q   <= 1'b0;
      output_data_q <= '0;
      last_out_q    <= 1'b0;
      count_out_q   <= '0;
    end else begin
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      valid_out_q   <= valid_out_d;
      output_data_q <= output_data_d;
      last_out_q    <= last_out_d;
      count_out_q   <= count_out_d;
    end
  end

  assign valid_out   = valid_out_q;
  assign output_data = output_data_q;
  assign last_out    = last_out_q;
  assign count_out   = count_out_q;

endmodule

// File: tb/tb_maxpool1d_stream.sv
// Bench for maxpool1d_stream. Four instances with POOL_K = 1..4 (index i has
// POOL_K = i+1). Stimulus pushes hand-computed results into a scoreboard
// queue; a monitor pops and compares on every output drain.
module tb_maxpool1d_stream;

  logic        clk;
  logic        rst_n;
  logic        vin  [4];
  logic        rin  [4];
  logic [31:0] din  [4];
  logic        lin  [4];
  logic        vout [4];
  logic        rout [4];
  logic [31:0] dout [4];
  logic        lout [4];
  logic [7:0]  cout [4];

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [7:0]  count;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    maxpool1d_stream #(
      .DATA_W (32),
      .POOL_K (g + 1)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_in    (vin[g]),
      .ready_in    (rin[g]),
      .input_data  (din[g]),
      .last_in     (lin[g]),
      .valid_out   (vout[g]),
      .ready_out   (rout[g]),
      .output_data (dout[g]),
      .last_out    (lout[g]),
      .count_out   (cout[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_res(input int id, input logic [31:0] d, input logic [7:0] c,
                            input logic l);
    exp_t e;
    e.id = id; e.data = d; e.count = c; e.last = l;
    q.push_back(e);
  endtask

  // Present one beat to instance i; returns #1 after the accepting edge.
  task automatic send(input int i, input logic [31:0] d, input logic l);
    bit acc;
    int n;
    vin[i] = 1'b1; din[i] = d; lin[i] = l;
    n = 0;
    do begin
      @(negedge clk);
      acc = rin[i];
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) check("send_timeout", 32'(n), 32'd0);
    vin[i] = 1'b0; lin[i] = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: a drain happens on the next rising edge when valid & ready.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_n && vout[i] && rout[i]) begin
        if (q.size() == 0) begin
          check("unexpected_result", dout[i], 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result_instance", 32'(i), 32'(e.id));
          check("result_data", dout[i], e.data);
          check("result_count", {24'd0, cout[i]}, {24'd0, e.count});
          check("result_last", {31'd0, lout[i]}, {31'd0, e.last});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      vin[i] = 1'b0; din[i] = '0; lin[i] = 1'b0; rout[i] = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("reset_ready_in", {31'd0, rin[i]}, 32'd1);
      check("reset_valid_out", {31'd0, vout[i]}, 32'd0);
      check("reset_data", dout[i], 32'd0);
      check("reset_count", {24'd0, cout[i]}, 32'd0);
      check("reset_last", {31'd0, lout[i]}, 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // POOL_K=2: 3,7,9,2 -> 7 and 9, each one cycle after its second word.
    expect_res(1, 32'd7, 8'd2, 1'b0);
    expect_res(1, 32'd9, 8'd2, 1'b0);
    send(1, 32'd3, 1'b0);
    check("k2_no_early_valid", {31'd0, vout[1]}, 32'd0);
    send(1, 32'd7, 1'b0);
    check("k2_latency_valid", {31'd0, vout[1]}, 32'd1);
    check("k2_latency_data", dout[1], 32'd7);
    send(1, 32'd9, 1'b0);
    send(1, 32'd2, 1'b0);
    check("k2_latency_data2", dout[1], 32'd9);
    wait_empty();

    // POOL_K=3: 5, 1(last) -> 5 count 2 last; then 4,4,4 -> 4 count 3.
    expect_res(2, 32'd5, 8'd2, 1'b1);
    expect_res(2, 32'd4, 8'd3, 1'b0);
    send(2, 32'd5, 1'b0);
    send(2, 32'd1, 1'b1);
    send(2, 32'd4, 1'b0);
    send(2, 32'd4, 1'b0);
    send(2, 32'd4, 1'b0);
    wait_empty();

    // Backpressure on POOL_K=2: result 7 held while further beats wait.
    rout[1] = 1'b0;
    expect_res(1, 32'd7, 8'd2, 1'b0);
    expect_res(1, 32'd5, 8'd2, 1'b0);
    send(1, 32'd3, 1'b0);
    send(1, 32'd7, 1'b0);
    fork
      begin
        send(1, 32'd1, 1'b0);
        send(1, 32'd5, 1'b0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_ready_in", {31'd0, rin[1]}, 32'd0);
          check("bp_valid_out", {31'd0, vout[1]}, 32'd1);
          check("bp_data_hold", dout[1], 32'd7);
        end
        @(posedge clk);
        #1;
        rout[1] = 1'b1;
      end
    join
    wait_empty();

    // Signed compare on POOL_K=2.
    expect_res(1, 32'hFFFF_FFFB, 8'd2, 1'b0);
    expect_res(1, 32'h7FFF_FFFF, 8'd2, 1'b0);
    send(1, 32'hFFFF_FFFB, 1'b0);
    send(1, 32'hFFFF_FFF7, 1'b0);
    send(1, 32'h8000_0000, 1'b0);
    send(1, 32'h7FFF_FFFF, 1'b0);
    wait_empty();

    // POOL_K=1 back-to-back stream: valid_out never drops.
    for (int j = 1; j <= 8; j++) expect_res(0, 32'(j), 8'd1, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      send(0, 32'(j), 1'b0);
      check("k1_valid_stream", {31'd0, vout[0]}, 32'd1);
      check("k1_stream_data", dout[0], 32'(j));
    end
    wait_empty();

    // Reset mid-window on POOL_K=4: the pre-reset word must be discarded.
    send(3, 32'd100, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", {31'd0, vout[3]}, 32'd0);
    check("midrst_ready_in", {31'd0, rin[3]}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_res(3, 32'd6, 8'd4, 1'b0);
    send(3, 32'd2, 1'b0);
    send(3, 32'd6, 1'b0);
    send(3, 32'd1, 1'b0);
    check("midrst_no_early", {31'd0, vout[3]}, 32'd0);
    send(3, 32'd3, 1'b0);
    wait_empty();

    repeat (5) @(posedge clk);
    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
